// File: rtl/multicycle_control_if.sv
// rtl/multicycle_control_if.sv - control/datapath signal bundle for the multi-cycle RV32I control FSM
// Optional trap output is present when MULTICYCLE_CONTROL_TRAP_EN is defined.
interface multicycle_control_if;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       zero;
  logic       mem_ready;
  logic       mem_req;
  logic       mem_read;
  logic       mem_write;
  logic       i_or_d;
  logic       ir_write;
  logic       pc_write;
  logic       pc_src;
  logic       reg_write;
  logic       mem_to_reg;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic       instr_done;
  logic       mem_err;
  logic [3:0] state;
`ifdef MULTICYCLE_CONTROL_TRAP_EN
  logic       illegal_instr;
`endif

  modport master (
`ifdef MULTICYCLE_CONTROL_TRAP_EN
    output illegal_instr,
`endif
    input  opcode, funct3, zero, mem_ready,
    output mem_req, mem_read, mem_write, i_or_d, ir_write, pc_write, pc_src,
    output reg_write, mem_to_reg, alu_src_a, alu_src_b, alu_op, instr_done,
    output mem_err, state
  );

  modport slave (
`ifdef MULTICYCLE_CONTROL_TRAP_EN
    input  illegal_instr,
`endif
    output opcode, funct3, zero, mem_ready,
    input  mem_req, mem_read, mem_write, i_or_d, ir_write, pc_write, pc_src,
    input  reg_write, mem_to_reg, alu_src_a, alu_src_b, alu_op, instr_done,
    input  mem_err, state
  );
endinterface

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - main control FSM of the multi-cycle RV32I core
// Define MULTICYCLE_CONTROL_TRAP_EN to turn illegal opcodes into a sticky TRAP state.
module multicycle_control #(
  parameter int MEM_TIMEOUT = 0
) (
  input logic                 clk,
  input logic                 rst,
  multicycle_control_if.master bus
);

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    EXEC_R    = 4'd2,
    EXEC_I    = 4'd3,
    EXEC_LUI  = 4'd4,
    ALU_WB    = 4'd5,
    MEM_ADDR  = 4'd6,
    MEM_READ  = 4'd7,
    MEM_WB    = 4'd8,
    MEM_WRITE = 4'd9,
    BRANCH    = 4'd10,
    ILLEGAL   = 4'd11,
    TRAP      = 4'd12
  } state_e;

  localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LAST_WAIT = CW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  state_e          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic            mem_err_q, mem_err_d;
  logic            waiting;
  logic            timeout;

  assign waiting = ((state_q == FETCH) || (state_q == MEM_READ) || (state_q == MEM_WRITE))
                   && !bus.mem_ready;
  // Fires on the MEM_TIMEOUT-th consecutive non-ready cycle of one request.
  assign timeout = (MEM_TIMEOUT > 0) && waiting && (count_q == LAST_WAIT);

  always_comb begin
    state_d   = state_q;
    mem_err_d = mem_err_q | timeout;
    unique case (state_q)
      FETCH:     if (bus.mem_ready) state_d = DECODE;
      DECODE: begin
        unique case (bus.opcode)
          7'b0000011, 7'b0100011: state_d = MEM_ADDR;
          7'b0110011:             state_d = EXEC_R;
          7'b0010011:             state_d = EXEC_I;
          7'b1100011:             state_d = BRANCH;
          7'b0110111:             state_d = EXEC_LUI;
          default:                state_d = ILLEGAL;
        endcase
      end
      EXEC_R, EXEC_I, EXEC_LUI: state_d = ALU_WB;
      ALU_WB, MEM_WB, BRANCH:   state_d = FETCH;
      MEM_ADDR:  state_d = (bus.opcode == 7'b0000011) ? MEM_READ : MEM_WRITE;
      MEM_READ:  if (bus.mem_ready) state_d = MEM_WB;
      MEM_WRITE: if (bus.mem_ready) state_d = FETCH;
`ifdef MULTICYCLE_CONTROL_TRAP_EN
      ILLEGAL:   state_d = TRAP;
      TRAP:      state_d = TRAP;
`else
      ILLEGAL:   state_d = FETCH;
`endif
      default:   state_d = FETCH;
    endcase
    if (timeout) state_d = FETCH;

    if (timeout || (state_d != state_q)) count_d = '0;
    else if (waiting)                    count_d = count_q + 1'b1;
    else                                 count_d = count_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= FETCH;
      count_q   <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      mem_err_q <= mem_err_d;
    end
  end

  assign bus.state   = state_q;
  assign bus.mem_err = mem_err_q;

  // Strobes are held low while rst is asserted so nothing commits during reset.
  always_comb begin
    bus.mem_req    = 1'b0;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.i_or_d     = 1'b0;
    bus.ir_write   = 1'b0;
    bus.pc_write   = 1'b0;
    bus.pc_src     = 1'b0;
    bus.reg_write  = 1'b0;
    bus.mem_to_reg = 1'b0;
    bus.alu_src_a  = 1'b0;
    bus.alu_src_b  = 2'b00;
    bus.alu_op     = 2'b00;
    bus.instr_done = 1'b0;
`ifdef MULTICYCLE_CONTROL_TRAP_EN
    bus.illegal_instr = 1'b0;
`endif
    if (!rst) begin
      unique case (state_q)
        FETCH: begin
          bus.mem_req   = 1'b1;
          bus.mem_read  = 1'b1;
          bus.alu_src_b = 2'b01;
          bus.ir_write  = bus.mem_ready;
          bus.pc_write  = bus.mem_ready;
        end
        DECODE:    bus.alu_src_b = 2'b10;
        EXEC_R: begin
          bus.alu_src_a = 1'b1;
          bus.alu_op    = 2'b10;
        end
        EXEC_I: begin
          bus.alu_src_a = 1'b1;
          bus.alu_src_b = 2'b10;
          bus.alu_op    = (bus.funct3 == 3'b000) ? 2'b00 : 2'b10;
        end
        EXEC_LUI: begin
          bus.alu_src_b = 2'b10;
          bus.alu_op    = 2'b11;
        end
        ALU_WB: begin
          bus.reg_write  = 1'b1;
          bus.instr_done = 1'b1;
        end
        MEM_ADDR: begin
          bus.alu_src_a = 1'b1;
          bus.alu_src_b = 2'b10;
        end
        MEM_READ: begin
          bus.mem_req  = 1'b1;
          bus.mem_read = 1'b1;
          bus.i_or_d   = 1'b1;
        end
        MEM_WB: begin
          bus.reg_write  = 1'b1;
          bus.mem_to_reg = 1'b1;
          bus.instr_done = 1'b1;
        end
        MEM_WRITE: begin
          bus.mem_req    = 1'b1;
          bus.mem_write  = 1'b1;
          bus.i_or_d     = 1'b1;
          bus.instr_done = bus.mem_ready;
        end
        BRANCH: begin
          bus.alu_src_a  = 1'b1;
          bus.alu_op     = 2'b01;
          bus.pc_write   = bus.zero ^ bus.funct3[0];
          bus.pc_src     = 1'b1;
          bus.instr_done = 1'b1;
        end
`ifdef MULTICYCLE_CONTROL_TRAP_EN
        TRAP:      bus.illegal_instr = 1'b1;
`else
        ILLEGAL:   bus.instr_done = 1'b1;
`endif
        default: ;
      endcase
    end
  end

endmodule
